// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: segment bit order, hex pattern table, digit count.
// Used by the capture block and by the counter display driver.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEG_W      = 7;

  // Segment a is the MSB of a pattern, g the LSB; a 1 means the segment is lit.
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F_POS = 1;
  localparam int SEG_G = 0;

  localparam logic [SEG_W-1:0] SEG_0 = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b1111011;
  localparam logic [SEG_W-1:0] SEG_A_HEX = 7'b1110111;
  localparam logic [SEG_W-1:0] SEG_B_HEX = 7'b0011111;
  localparam logic [SEG_W-1:0] SEG_C_HEX = 7'b1001110;
  localparam logic [SEG_W-1:0] SEG_D_HEX = 7'b0111101;
  localparam logic [SEG_W-1:0] SEG_E_HEX = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_F_HEX = 7'b1000111;

  // Entry n holds the pattern that displays hex value n.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    SEG_F_HEX, SEG_E_HEX, SEG_D_HEX, SEG_C_HEX, SEG_B_HEX, SEG_A_HEX, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  function automatic logic single_low(input logic [NUM_DIGITS-1:0] g);
    return ($countones(~g) == 1);
  endfunction

  function automatic logic [1:0] low_index(input logic [NUM_DIGITS-1:0] g);
    logic [1:0] idx;
    idx = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!g[k]) idx = 2'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational segment-pattern to hex-nibble decoder; zero latency, no backpressure.
// valid_o is low for any pattern outside the hex table.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output logic [3:0]       nibble_o,
  output logic             valid_o
);

  always_comb begin
    nibble_o = '0;
    valid_o  = 1'b0;
    for (int n = 0; n < 16; n++) begin
      if (seg_i == SEG_TABLE[n]) begin
        nibble_o = 4'(n);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_segment_capture.sv
// Captures hex digits from a multiplexed 7-segment display via synchronizers and a stability filter.
// Outputs update 2+STABLE_CYCLES edges after an input change; no backpressure (free-running observer).
module seven_segment_capture
  import seven_seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   grounds,
  input  logic [SEG_W-1:0]        display,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    seg_err,
  output logic [1:0]              err_digit
);

  localparam int SYNC_W = NUM_DIGITS + SEG_W;
  localparam logic [SYNC_W-1:0] SYNC_RST   = {{NUM_DIGITS{1'b1}}, {SEG_W{1'b0}}};
  localparam logic [7:0]        CNT_MAX    = 8'(STABLE_CYCLES);
  localparam logic [7:0]        CNT_ACCEPT = 8'(STABLE_CYCLES - 1);

  logic [SYNC_W-1:0] meta_q, sync_q;
  logic [7:0]        cnt_q, cnt_d;
  logic              armed_q, armed_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic              frame_done_q, frame_done_d;
  logic              seg_err_q, seg_err_d;
  logic [1:0]        err_digit_q, err_digit_d;

  logic [NUM_DIGITS-1:0] grounds_s;
  logic [SEG_W-1:0]      seg_s;
  logic                  changed;
  logic                  accept;
  logic [1:0]            idx;
  logic [3:0]            dec_nibble;
  logic                  dec_valid;

  assign grounds_s = sync_q[SYNC_W-1:SEG_W];
  assign seg_s     = sync_q[SEG_W-1:0];
  // The value entering the second stage is next cycle's synchronized sample; comparing
  // against it starts the stability count on the edge the synchronized value changes.
  assign changed   = (meta_q != sync_q);
  assign idx       = low_index(grounds_s);
  assign accept    = armed_q && !changed && (cnt_q == CNT_ACCEPT) && single_low(grounds_s);

  seven_seg_decode u_decode (
    .seg_i    (seg_s),
    .nibble_o (dec_nibble),
    .valid_o  (dec_valid)
  );

  always_comb begin
    cnt_d        = cnt_q;
    armed_d      = armed_q;
    seen_d       = seen_q;
    digits_d     = digits_q;
    valid_d      = valid_q;
    frame_done_d = 1'b0;
    seg_err_d    = 1'b0;
    err_digit_d  = err_digit_q;

    if (changed) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end

    // Frame closes one edge after the last digit is seen; a capture on that edge opens the next frame.
    if (seen_q == '1) begin
      frame_done_d = 1'b1;
      seen_d       = '0;
    end

    if (accept) begin
      armed_d     = 1'b0;
      seen_d[idx] = 1'b1;
      if (dec_valid) begin
        digits_d[{idx, 2'b00} +: 4] = dec_nibble;
        valid_d[idx]                = 1'b1;
      end else begin
        valid_d[idx] = 1'b0;
        seg_err_d    = 1'b1;
        err_digit_d  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q       <= SYNC_RST;
      sync_q       <= SYNC_RST;
      cnt_q        <= '0;
      armed_q      <= 1'b0;
      seen_q       <= '0;
      digits_q     <= '0;
      valid_q      <= '0;
      frame_done_q <= 1'b0;
      seg_err_q    <= 1'b0;
      err_digit_q  <= '0;
    end else begin
      meta_q       <= {grounds, display};
      sync_q       <= meta_q;
      cnt_q        <= cnt_d;
      armed_q      <= armed_d;
      seen_q       <= seen_d;
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
      seg_err_q    <= seg_err_d;
      err_digit_q  <= err_digit_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign frame_done  = frame_done_q;
  assign seg_err     = seg_err_q;
  assign err_digit   = err_digit_q;

endmodule
